// File: rtl/bsg_tunnel_credit_arbiter_if.sv
// Handshake bundle for the tunnel credit arbiter: per-channel input side,
// the tagged output stage and the credit-return / credit-visibility side.
interface bsg_tunnel_credit_arbiter_if #(
    parameter int width_p          = 8,
    parameter int num_in_p         = 4,
    parameter int remote_credits_p = 2
);
    localparam int tag_width_lp    = $clog2(num_in_p + 1);
    localparam int credit_width_lp = $clog2(remote_credits_p + 1);

    logic [num_in_p*width_p-1:0]         data_i;
    logic [num_in_p-1:0]                 v_i;
    logic [num_in_p-1:0]                 yumi_o;
    logic [tag_width_lp+width_p-1:0]     multi_data_o;
    logic                                multi_v_o;
    logic                                multi_yumi_i;
    logic                                credit_v_i;
    logic [tag_width_lp-1:0]             credit_id_i;
    logic [credit_width_lp-1:0]          credit_count_i;
    logic [num_in_p*credit_width_lp-1:0] credit_avail_o;

    modport slave (
        input  data_i, v_i, multi_yumi_i, credit_v_i, credit_id_i, credit_count_i,
        output yumi_o, multi_data_o, multi_v_o, credit_avail_o
    );

    modport master (
        output data_i, v_i, multi_yumi_i, credit_v_i, credit_id_i, credit_count_i,
        input  yumi_o, multi_data_o, multi_v_o, credit_avail_o
    );
endinterface

// File: rtl/bsg_tunnel_credit_arbiter.sv
// Credit-gated round-robin scheduler that funnels num_in_p channels into one
// tagged output register; credits come back from the far-side demux.
module bsg_tunnel_credit_arbiter #(
    parameter int width_p          = 8,
    parameter int num_in_p         = 4,
    parameter int remote_credits_p = 2
) (
    input logic                     clk_i,
    input logic                     reset_i,
    bsg_tunnel_credit_arbiter_if.slave io
);
    localparam int tag_width_lp    = $clog2(num_in_p + 1);
    localparam int credit_width_lp = $clog2(remote_credits_p + 1);

    typedef logic [credit_width_lp-1:0] credit_t;

    credit_t                         credit_q [num_in_p];
    credit_t                         credit_d [num_in_p];
    logic [tag_width_lp-1:0]         ptr_q, ptr_d;
    logic                            multi_v_q, multi_v_d;
    logic [tag_width_lp+width_p-1:0] multi_data_q, multi_data_d;

    logic [num_in_p-1:0]                 elig;
    logic [num_in_p-1:0]                 yumi;
    logic [num_in_p-1:0]                 credit_over;
    logic                                load_en;
    logic                                grant_v;
    logic [tag_width_lp-1:0]             grant_id;
    logic [width_p-1:0]                  payload;
    logic [num_in_p*credit_width_lp-1:0] credit_avail;

    // Grant selection: first eligible channel at or after the pointer.
    always_comb begin
        int idx;
        grant_v  = 1'b0;
        grant_id = '0;
        load_en  = ~multi_v_q | io.multi_yumi_i;
        for (int i = 0; i < num_in_p; i++) begin
            elig[i] = io.v_i[i] & (credit_q[i] != '0);
        end
        for (int k = 0; k < num_in_p; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= num_in_p) idx = idx - num_in_p;
            for (int i = 0; i < num_in_p; i++) begin
                if (!grant_v && elig[i] && (idx == i)) begin
                    grant_v  = 1'b1;
                    grant_id = tag_width_lp'(i);
                end
            end
        end
        // Nothing leaves a channel during reset or while the output is full.
        if (reset_i || !load_en) begin
            grant_v = 1'b0;
        end
        payload = '0;
        for (int i = 0; i < num_in_p; i++) begin
            yumi[i] = grant_v & (grant_id == tag_width_lp'(i));
            if (grant_id == tag_width_lp'(i)) begin
                payload = io.data_i[i*width_p +: width_p];
            end
        end
    end

    // Next state: output stage, pointer and per-channel credit counters.
    always_comb begin
        int  nxt;
        logic ret;
        multi_v_d    = multi_v_q;
        multi_data_d = multi_data_q;
        ptr_d        = ptr_q;
        if (grant_v) begin
            multi_v_d    = 1'b1;
            multi_data_d = {grant_id, payload};
            ptr_d        = (grant_id == tag_width_lp'(num_in_p - 1)) ? '0 : grant_id + 1'b1;
        end else if (io.multi_yumi_i) begin
            multi_v_d = 1'b0;
        end
        for (int i = 0; i < num_in_p; i++) begin
            ret            = io.credit_v_i && (io.credit_id_i == tag_width_lp'(i));
            credit_d[i]    = credit_q[i] - credit_t'(yumi[i]) + (ret ? io.credit_count_i : '0);
            nxt            = int'(credit_q[i]) - int'(yumi[i]) + (ret ? int'(io.credit_count_i) : 0);
            credit_over[i] = nxt > remote_credits_p;
            credit_avail[i*credit_width_lp +: credit_width_lp] = credit_q[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            multi_v_q    <= 1'b0;
            multi_data_q <= '0;
            ptr_q        <= '0;
            for (int i = 0; i < num_in_p; i++) begin
                credit_q[i] <= credit_t'(remote_credits_p);
            end
        end else begin
            multi_v_q    <= multi_v_d;
            multi_data_q <= multi_data_d;
            ptr_q        <= ptr_d;
            for (int i = 0; i < num_in_p; i++) begin
                credit_q[i] <= credit_d[i];
            end
            assert (credit_over == '0);
            assert (!(io.credit_v_i && (io.credit_id_i >= tag_width_lp'(num_in_p))));
            assert (!(io.multi_yumi_i && !multi_v_q));
        end
    end

    assign io.yumi_o         = yumi;
    assign io.multi_v_o      = multi_v_q;
    assign io.multi_data_o   = multi_data_q;
    assign io.credit_avail_o = credit_avail;
endmodule
